// File: rtl/fetch_ctrl_if.sv
// Instruction-fetch bundle between fetch_ctrl, instruction memory and the
// decode/execute datapath. The master modport is the fetch controller; the
// slave modport is everything around it (memory plus datapath).
interface fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        redir_valid;
  logic        redir_jalr;
  logic [31:0] redir_target;
  logic        halt;
  logic        trap_valid;
  logic [31:0] trap_pc;
  logic [31:0] instret;

  modport master (
    output imem_req, imem_addr, inst, pc, inst_valid, trap_valid, trap_pc, instret,
    input  imem_gnt, imem_rvalid, imem_rdata, inst_ready, redir_valid, redir_jalr,
           redir_target, halt
  );

  modport slave (
    input  imem_req, imem_addr, inst, pc, inst_valid, trap_valid, trap_pc, instret,
    output imem_gnt, imem_rvalid, imem_rdata, inst_ready, redir_valid, redir_jalr,
           redir_target, halt
  );
endinterface

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: multi-cycle RV32I instruction-fetch and PC sequencer.
// One outstanding imem transaction at a time; the fetched word is held for
// the datapath until it retires, then the PC advances or is redirected.
// Optional feature macro: MISALIGN_TRAP_EN (redirects to a target with
// t[1:0] != 0 divert to TRAP_VEC and pulse trap_valid). Without it the
// target's low two bits are simply cleared.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input logic          clk,
  input logic          rst,
  fetch_ctrl_if.master bus
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, HALTED} state_t;

  state_t      state;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic        inst_valid_q;
  logic        req_q;
  logic [31:0] instret_q;
  logic        retire;
  logic [31:0] tgt;

  // JALR clears bit 0; without the trap feature the word alignment is forced.
  function automatic logic [31:0] redir_addr(input logic [31:0] target, input logic jalr);
    logic [31:0] t;
    t = target;
    if (jalr) t[0] = 1'b0;
`ifndef MISALIGN_TRAP_EN
    t[1:0] = 2'b00;
`endif
    return t;
  endfunction

  assign retire = inst_valid_q && bus.inst_ready;
  assign tgt    = redir_addr(bus.redir_target, bus.redir_jalr);

`ifdef MISALIGN_TRAP_EN
  logic        trap_valid_q;
  logic [31:0] trap_pc_q;
  logic        misaligned;

  assign misaligned = bus.redir_valid && (tgt[1:0] != 2'b00);

  // Trap reporting: one-cycle pulse after a retire that redirects off-word.
  always_ff @(posedge clk) begin
    if (rst) begin
      trap_valid_q <= 1'b0;
      trap_pc_q    <= 32'h0;
    end else begin
      trap_valid_q <= 1'b0;
      if (state == HOLD && retire && misaligned) begin
        trap_valid_q <= 1'b1;
        trap_pc_q    <= pc_q;
      end
    end
  end

  assign bus.trap_valid = trap_valid_q;
  assign bus.trap_pc    = trap_pc_q;
`else
  wire [31:0] unused_trap_vec = TRAP_VEC;
  assign bus.trap_valid = 1'b0;
  assign bus.trap_pc    = 32'h0;
`endif

  // Fetch sequencer: request, wait for data, hold until retire, advance PC.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pc_q         <= RESET_PC;
      inst_q       <= 32'h0;
      inst_valid_q <= 1'b0;
      req_q        <= 1'b0;
      instret_q    <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          req_q <= 1'b1;
          state <= REQ;
        end
        REQ: begin
          if (bus.imem_gnt) begin
            req_q <= 1'b0;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (bus.imem_rvalid) begin
            inst_q       <= bus.imem_rdata;
            inst_valid_q <= 1'b1;
            state        <= HOLD;
          end
        end
        HOLD: begin
          if (retire) begin
            instret_q    <= instret_q + 32'd1;
            inst_valid_q <= 1'b0;
`ifdef MISALIGN_TRAP_EN
            if (misaligned)           pc_q <= TRAP_VEC;
            else if (bus.redir_valid) pc_q <= tgt;
            else                      pc_q <= pc_q + 32'd4;
`else
            pc_q <= bus.redir_valid ? tgt : pc_q + 32'd4;
`endif
            if (bus.halt) begin
              req_q <= 1'b0;
              state <= HALTED;
            end else begin
              req_q <= 1'b1;
              state <= REQ;
            end
          end
        end
        HALTED: begin
          req_q        <= 1'b0;
          inst_valid_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.imem_req   = req_q;
  assign bus.imem_addr  = pc_q;
  assign bus.pc         = pc_q;
  assign bus.inst       = inst_q;
  assign bus.inst_valid = inst_valid_q;
  assign bus.instret    = instret_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl. Expectations for the
// misaligned-target case follow MISALIGN_TRAP_EN as compiled.
module tb_fetch_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  fetch_ctrl_if bus ();

  fetch_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one fetch from REQ to HOLD with the given gnt/rvalid delays.
  task automatic fetch(input int gd, input int rd, input logic [31:0] data,
                       input logic [31:0] addr);
    check("req_on", {31'b0, bus.imem_req}, 32'd1);
    check("addr", bus.imem_addr, addr);
    for (int i = 0; i < gd; i++) begin
      bus.imem_rvalid = 1'b1;   // must be ignored while in REQ
      tick();
      check("req_hold", {31'b0, bus.imem_req}, 32'd1);
      check("addr_hold", bus.imem_addr, addr);
      check("no_valid_req", {31'b0, bus.inst_valid}, 32'd0);
    end
    bus.imem_rvalid = 1'b0;
    bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt = 1'b0;
    check("req_off_wait", {31'b0, bus.imem_req}, 32'd0);
    for (int i = 0; i < rd; i++) begin
      tick();
      check("no_valid_wait", {31'b0, bus.inst_valid}, 32'd0);
    end
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = data;
    tick();
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'hDEAD_BEEF;
    check("inst_valid", {31'b0, bus.inst_valid}, 32'd1);
    check("inst", bus.inst, data);
    check("pc", bus.pc, addr);
  endtask

  task automatic retire(input logic rv, input logic jalr, input logic [31:0] tgt,
                        input logic hlt);
    bus.inst_ready   = 1'b1;
    bus.redir_valid  = rv;
    bus.redir_jalr   = jalr;
    bus.redir_target = tgt;
    bus.halt         = hlt;
    tick();
    bus.inst_ready   = 1'b0;
    bus.redir_valid  = 1'b0;
    bus.redir_jalr   = 1'b0;
    bus.redir_target = 32'h0;
    bus.halt         = 1'b0;
    check("valid_drop", {31'b0, bus.inst_valid}, 32'd0);
  endtask

  logic [31:0] after_trap;

  initial begin
    rst = 1'b1;
    bus.imem_gnt     = 1'b0;
    bus.imem_rvalid  = 1'b0;
    bus.imem_rdata   = 32'h0;
    bus.inst_ready   = 1'b0;
    bus.redir_valid  = 1'b0;
    bus.redir_jalr   = 1'b0;
    bus.redir_target = 32'h0;
    bus.halt         = 1'b0;
    tick();
    tick();
    check("rst_req", {31'b0, bus.imem_req}, 32'd0);
    check("rst_valid", {31'b0, bus.inst_valid}, 32'd0);
    check("rst_pc", bus.pc, 32'h0);
    check("rst_inst", bus.inst, 32'h0);
    check("rst_instret", bus.instret, 32'h0);
    check("rst_trap", {31'b0, bus.trap_valid}, 32'd0);
    check("rst_trap_pc", bus.trap_pc, 32'h0);

    // First cycle after reset release is IDLE, request follows.
    rst = 1'b0;
    check("idle_req", {31'b0, bus.imem_req}, 32'd0);
    tick();

    // Back-to-back best-case fetches at 0, 4, 8.
    fetch(0, 0, 32'h0050_0093, 32'h0);
    retire(1'b0, 1'b0, 32'h0, 1'b0);
    fetch(0, 0, 32'h0050_0093, 32'h4);
    retire(1'b0, 1'b0, 32'h0, 1'b0);
    fetch(0, 0, 32'h0050_0093, 32'h8);
    retire(1'b0, 1'b0, 32'h0, 1'b0);
    check("instret3", bus.instret, 32'd3);

    // Slow memory: gnt after 3 cycles, rvalid 2 more after.
    fetch(3, 2, 32'h1234_5678, 32'hC);
    // Hold without retire: redir/halt are don't-care, inst/pc stable.
    bus.redir_valid = 1'b1;
    bus.halt = 1'b1;
    bus.redir_target = 32'h0000_0200;
    tick();
    tick();
    check("hold_valid", {31'b0, bus.inst_valid}, 32'd1);
    check("hold_inst", bus.inst, 32'h1234_5678);
    check("hold_pc", bus.pc, 32'hC);
    check("hold_no_req", {31'b0, bus.imem_req}, 32'd0);
    retire(1'b0, 1'b0, 32'h0, 1'b0);
    check("instret4", bus.instret, 32'd4);

    // JALR at 0x10 to 0x41 -> 0x40.
    fetch(0, 0, 32'h0000_8067, 32'h10);
    retire(1'b1, 1'b1, 32'h0000_0041, 1'b0);
    check("jalr_addr", bus.imem_addr, 32'h40);

    // Branch at 0x40 to 0x20.
    fetch(0, 0, 32'h0000_0063, 32'h40);
    retire(1'b1, 1'b0, 32'h0000_0020, 1'b0);

    // Misaligned target at 0x20 to 0x42.
    fetch(1, 1, 32'h0000_006F, 32'h20);
    retire(1'b1, 1'b0, 32'h0000_0042, 1'b0);
`ifdef MISALIGN_TRAP_EN
    after_trap = 32'h100;
    check("trap_pulse", {31'b0, bus.trap_valid}, 32'd1);
    check("trap_pc", bus.trap_pc, 32'h20);
`else
    after_trap = 32'h40;
    check("trap_pulse", {31'b0, bus.trap_valid}, 32'd0);
    check("trap_pc", bus.trap_pc, 32'h0);
`endif
    check("trap_addr", bus.imem_addr, after_trap);
    check("instret7", bus.instret, 32'd7);
    tick();
    check("trap_end", {31'b0, bus.trap_valid}, 32'd0);

    // Reset during WAIT; stale rvalid after release is ignored.
    check("pre_wait_addr", bus.imem_addr, after_trap);
    bus.imem_gnt = 1'b1;
    tick();
    bus.imem_gnt = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hBAD0_BAD0;
    tick();
    tick();
    bus.imem_rvalid = 1'b0;
    check("stale_valid", {31'b0, bus.inst_valid}, 32'd0);
    check("stale_pc", bus.pc, 32'h0);
    check("stale_instret", bus.instret, 32'd0);
    check("stale_inst", bus.inst, 32'h0);
    fetch(0, 0, 32'h0000_0013, 32'h0);
    retire(1'b0, 1'b0, 32'h0, 1'b0);

    // Halt on retire at 0x4.
    fetch(0, 0, 32'h0000_0073, 32'h4);
    retire(1'b0, 1'b0, 32'h0, 1'b1);
    check("halt_instret", bus.instret, 32'd2);
    bus.imem_gnt    = 1'b1;
    bus.imem_rvalid = 1'b1;
    bus.inst_ready  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("halt_req", {31'b0, bus.imem_req}, 32'd0);
      check("halt_valid", {31'b0, bus.inst_valid}, 32'd0);
    end
    check("halt_instret_frozen", bus.instret, 32'd2);
    check("halt_pc", bus.pc, 32'h8);
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.inst_ready  = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
